// File: rtl/dmem_arbiter.sv
// dmem_arbiter: lets the core load/store path and a debug/loader port share the
// single-port data memory.
//
// The core has priority. An anti-starvation counter forces a debug grant after
// MAX_WAIT consecutive denied debug cycles. Grants are combinational, in the same
// cycle as the request. Read data is registered and returned one cycle after the
// grant, together with a one-cycle rvalid pulse. rdata keeps its value after that.
//
// Optional feature: defining DMEM_ARB_LOCK_EN adds a LOCKED state. In that state
// the debug port keeps ownership of the memory while dbg_lock_i is high. When the
// macro is undefined, dbg_lock_i is ignored.
//
// Ports:
//   clk_i, reset_i           clock; synchronous active-low reset
//   core_req/we/addr/wdata_i core access request
//   core_gnt_o, core_stall_o core issued this cycle / core held off
//   core_rvalid/rdata_o      registered core read return
//   dbg_*                    same set of signals for the debug/loader port
//   dbg_lock_i               hold debug ownership (lock build only)
//   mem_we/re/addr/wdata_o   data memory command (granted port, else 0)
//   mem_rdata_i              data memory read data, valid with mem_re_o
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  core_req_i,
  input  logic                  core_we_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_i,
  output logic                  core_gnt_o,
  output logic                  core_stall_o,
  output logic                  core_rvalid_o,
  output logic [DATA_WIDTH-1:0] core_rdata_o,
  input  logic                  dbg_req_i,
  input  logic                  dbg_we_i,
  input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
  input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
  output logic                  dbg_gnt_o,
  output logic                  dbg_rvalid_o,
  output logic [DATA_WIDTH-1:0] dbg_rdata_o,
  input  logic                  dbg_lock_i,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       wait_cnt_q, wait_cnt_d;
  logic                  lock_hold;
  logic                  core_rvalid_q, dbg_rvalid_q;
  logic [DATA_WIDTH-1:0] core_rdata_q, dbg_rdata_q;

`ifndef DMEM_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = dbg_lock_i;
`endif

  always_comb begin
    state_d    = state_q;
    lock_hold  = 1'b0;
    core_gnt_o = 1'b0;
    dbg_gnt_o  = 1'b0;
    wait_cnt_d = '0;

`ifdef DMEM_ARB_LOCK_EN
    // Once the lock drops, normal arbitration resumes in that same cycle.
    lock_hold = (state_q == StLocked) && dbg_lock_i;
`endif

    if (lock_hold) begin
      dbg_gnt_o = dbg_req_i;
    end else if (dbg_req_i && (!core_req_i || wait_cnt_q == CntW'(MAX_WAIT))) begin
      dbg_gnt_o = 1'b1;
    end else if (core_req_i) begin
      core_gnt_o = 1'b1;
    end

    if (state_q != StLocked && dbg_req_i && !dbg_gnt_o) begin
      wait_cnt_d = (wait_cnt_q == CntW'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + CntW'(1);
    end

`ifdef DMEM_ARB_LOCK_EN
    if (state_q == StIdle && dbg_gnt_o && dbg_lock_i) begin
      state_d = StLocked;
    end else if (state_q == StLocked && !dbg_lock_i) begin
      state_d = StIdle;
    end
`endif
  end

  assign core_stall_o = core_req_i & ~core_gnt_o;

  // At most one grant is active, so OR-ing the gated commands acts as the mux.
  assign mem_we_o    = (core_gnt_o & core_we_i) | (dbg_gnt_o & dbg_we_i);
  assign mem_re_o    = (core_gnt_o & ~core_we_i) | (dbg_gnt_o & ~dbg_we_i);
  assign mem_addr_o  = ({ADDR_WIDTH{core_gnt_o}} & core_addr_i) |
                       ({ADDR_WIDTH{dbg_gnt_o}} & dbg_addr_i);
  assign mem_wdata_o = ({DATA_WIDTH{core_gnt_o}} & core_wdata_i) |
                       ({DATA_WIDTH{dbg_gnt_o}} & dbg_wdata_i);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
      core_rdata_q  <= '0;
      dbg_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      core_rvalid_q <= core_gnt_o & ~core_we_i;
      dbg_rvalid_q  <= dbg_gnt_o & ~dbg_we_i;
      if (core_gnt_o && !core_we_i) core_rdata_q <= mem_rdata_i;
      if (dbg_gnt_o && !dbg_we_i)   dbg_rdata_q  <= mem_rdata_i;
    end
  end

  assign core_rvalid_o = core_rvalid_q;
  assign core_rdata_o  = core_rdata_q;
  assign dbg_rvalid_o  = dbg_rvalid_q;
  assign dbg_rdata_o   = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter. Vectors from a table and from a few hand-built
// sequences go through one apply task. That task checks the combinational
// grant and memory outputs, then checks the registered read return one cycle
// later. The expected read return is taken from a scoreboard queue.
module tb_dmem_arbiter;

  localparam int MaxWait = 4;

  typedef struct {
    bit          rst_n;
    bit          creq, cwe;
    logic [4:0]  ca;
    logic [31:0] cwd;
    bit          dreq, dwe;
    logic [4:0]  da;
    logic [31:0] dwd;
    bit          lock;
    logic [31:0] mrd;
    bit          ecg, edg;
  } vec_t;

  typedef struct {
    bit          crv, drv;
    logic [31:0] crd, drd;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        core_req, core_we, dbg_req, dbg_we, dbg_lock;
  logic [4:0]  core_addr, dbg_addr, mem_addr;
  logic [31:0] core_wdata, dbg_wdata, mem_rdata, mem_wdata, core_rdata, dbg_rdata;
  logic        core_gnt, core_stall, core_rvalid, dbg_gnt, dbg_rvalid, mem_we, mem_re;

  int n_checks = 0;
  int n_pass   = 0;
  sb_t sb_q[$];
  logic [31:0] mdl_crd = '0, mdl_drd = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .MAX_WAIT(MaxWait)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_gnt_o(core_gnt), .core_stall_o(core_stall),
    .core_rvalid_o(core_rvalid), .core_rdata_o(core_rdata),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid),
    .dbg_rdata_o(dbg_rdata), .dbg_lock_i(dbg_lock),
    .mem_we_o(mem_we), .mem_re_o(mem_re), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  function automatic vec_t mk(bit rst_n, bit creq, bit cwe, logic [4:0] ca, logic [31:0] cwd,
                              bit dreq, bit dwe, logic [4:0] da, logic [31:0] dwd,
                              bit lock, logic [31:0] mrd, bit ecg, bit edg);
    vec_t v;
    v.rst_n = rst_n; v.creq = creq; v.cwe = cwe; v.ca = ca; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.da = da; v.dwd = dwd; v.lock = lock;
    v.mrd = mrd; v.ecg = ecg; v.edg = edg;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic apply(input vec_t v, input string tag);
    sb_t e;
    logic [4:0]  e_addr;
    logic [31:0] e_wd;
    reset_i = v.rst_n; core_req = v.creq; core_we = v.cwe; core_addr = v.ca;
    core_wdata = v.cwd; dbg_req = v.dreq; dbg_we = v.dwe; dbg_addr = v.da;
    dbg_wdata = v.dwd; dbg_lock = v.lock; mem_rdata = v.mrd;
    #2;
    e_addr = v.edg ? v.da : (v.ecg ? v.ca : 5'd0);
    e_wd   = v.edg ? v.dwd : (v.ecg ? v.cwd : 32'd0);
    check({tag, " core_gnt"}, 32'(core_gnt), 32'(v.ecg));
    check({tag, " dbg_gnt"}, 32'(dbg_gnt), 32'(v.edg));
    check({tag, " core_stall"}, 32'(core_stall), 32'(v.creq & ~v.ecg));
    check({tag, " mem_we"}, 32'(mem_we), 32'((v.ecg & v.cwe) | (v.edg & v.dwe)));
    check({tag, " mem_re"}, 32'(mem_re), 32'((v.ecg & ~v.cwe) | (v.edg & ~v.dwe)));
    check({tag, " mem_addr"}, 32'(mem_addr), 32'(e_addr));
    check({tag, " mem_wdata"}, mem_wdata, e_wd);
    if (!v.rst_n) begin
      e.crv = 1'b0; e.drv = 1'b0; mdl_crd = '0; mdl_drd = '0;
    end else begin
      e.crv = v.ecg & ~v.cwe;
      e.drv = v.edg & ~v.dwe;
      if (e.crv) mdl_crd = v.mrd;
      if (e.drv) mdl_drd = v.mrd;
    end
    e.crd = mdl_crd; e.drd = mdl_drd;
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, " core_rvalid"}, 32'(core_rvalid), 32'(e.crv));
      check({tag, " core_rdata"}, core_rdata, e.crd);
      check({tag, " dbg_rvalid"}, 32'(dbg_rvalid), 32'(e.drv));
      check({tag, " dbg_rdata"}, dbg_rdata, e.drd);
    end
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = mk(1, 0,0,5'd0,32'h0,        0,0,5'd0,32'h0,        0, 32'h0,        0,0);
    tbl[1] = mk(1, 1,0,5'd3,32'h0,        0,0,5'd0,32'h0,        0, 32'hDEADBEEF, 1,0);
    tbl[2] = mk(1, 0,0,5'd0,32'h0,        1,1,5'd7,32'h12345678, 0, 32'h0,        0,1);
    tbl[3] = mk(1, 1,0,5'd1,32'h0,        0,0,5'd0,32'h0,        0, 32'h11111111, 1,0);
    tbl[4] = mk(1, 1,0,5'd2,32'h0,        0,0,5'd0,32'h0,        0, 32'h22222222, 1,0);
    tbl[5] = mk(1, 1,1,5'd9,32'hA5A5A5A5, 0,0,5'd0,32'h0,        0, 32'h0,        1,0);
    tbl[6] = mk(1, 0,0,5'd0,32'h0,        1,0,5'd4,32'h0,        0, 32'hCAFEF00D, 0,1);
    tbl[7] = mk(1, 1,0,5'd31,32'h0,       0,0,5'd0,32'h0,        0, 32'h0BADC0DE, 1,0);

    reset_i = 1'b0; core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    apply(mk(0, 0,0,5'd0,32'h0, 0,0,5'd0,32'h0, 0, 32'h0, 0,0), "reset");

    for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Both ports keep requesting: the core gets 4 grants, then debug gets 1.
    for (int i = 0; i < 10; i++)
      apply(mk(1, 1,0,5'(i),32'h0, 1,0,5'd20,32'h0, 0, 32'h100 + 32'(i),
               (i % 5) != 4, (i % 5) == 4), $sformatf("starve%0d", i));

    // When debug withdraws its request, the wait count restarts from zero.
    for (int i = 0; i < 2; i++)
      apply(mk(1, 1,0,5'd1,32'h0, 1,0,5'd2,32'h0, 0, 32'h200 + 32'(i), 1,0),
            $sformatf("wd_pre%0d", i));
    apply(mk(1, 1,0,5'd1,32'h0, 0,0,5'd2,32'h0, 0, 32'h210, 1,0), "wd_drop");
    for (int i = 0; i < 5; i++)
      apply(mk(1, 1,0,5'd1,32'h0, 1,0,5'd2,32'h0, 0, 32'h220 + 32'(i), i != 4, i == 4),
            $sformatf("wd_post%0d", i));

    // Reset in the cycle after a read grant drops rvalid and clears the wait count.
    for (int i = 0; i < 3; i++)
      apply(mk(1, 1,0,5'd6,32'h0, 1,0,5'd8,32'h0, 0, 32'h300 + 32'(i), 1,0),
            $sformatf("rst_pre%0d", i));
    apply(mk(0, 0,0,5'd0,32'h0, 0,0,5'd0,32'h0, 0, 32'h0, 0,0), "rst_mid");
    for (int i = 0; i < 5; i++)
      apply(mk(1, 1,0,5'd6,32'h0, 1,0,5'd8,32'h0, 0, 32'h310 + 32'(i), i != 4, i == 4),
            $sformatf("rst_post%0d", i));

    apply(mk(1, 0,0,5'd0,32'h0, 1,0,5'd10,32'h0, 1, 32'h77, 0,1), "lock_gnt");
`ifdef DMEM_ARB_LOCK_EN
    for (int i = 0; i < 3; i++)
      apply(mk(1, 1,0,5'd2,32'h0, 0,0,5'd0,32'h0, 1, 32'h0, 0,0), $sformatf("locked%0d", i));
    apply(mk(1, 0,0,5'd0,32'h0, 0,0,5'd0,32'h0, 0, 32'h0, 0,0), "unlock");
    apply(mk(1, 1,0,5'd2,32'h0, 0,0,5'd0,32'h0, 0, 32'h99, 1,0), "after_unlock");
`else
    apply(mk(1, 1,0,5'd2,32'h0, 0,0,5'd0,32'h0, 1, 32'h99, 1,0), "lock_ignored");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
